// File: rtl/simple_seq_ctrl.sv
// Instruction sequencer: fetches over imem req/ack, steps IF/ID/EX/WB, owns the PC.
// Optional illegal-opcode trap (and trap port) enabled by defining SIMPLE_SEQ_TRAP_EN.
module simple_seq_ctrl #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic [PC_W-1:0]    pc_incr,
    output logic [INSTR_W-1:0] INSTR,
    output logic [1:0]         phase,
    output logic [PC_W-1:0]    pc,
    output logic               instr_retired,
    output logic               halted
`ifdef SIMPLE_SEQ_TRAP_EN
    ,
    output logic               trap
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ID    = 3'd2,
        EX    = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t     state, next_state;
    logic [3:0] opcode;
    logic       opcode_legal;
    logic       fetch_done;
`ifdef SIMPLE_SEQ_TRAP_EN
    logic       set_trap;
`else
    logic       skip;
`endif

    // Opcode is decoded straight off the bus so the ack cycle can pick the next state.
    assign opcode    = imem_rdata[INSTR_W-1 -: 4];
    assign imem_addr = pc;

    always_comb begin
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9: opcode_legal = 1'b1;
            default:                                       opcode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state    = state;
        imem_req      = 1'b0;
        phase         = 2'd0;
        instr_retired = 1'b0;
        halted        = 1'b0;
        fetch_done    = 1'b0;
`ifdef SIMPLE_SEQ_TRAP_EN
        set_trap      = 1'b0;
`else
        skip          = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (run) next_state = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    if (opcode == 4'hF) begin
                        next_state = HALT;
                    end else if (opcode_legal) begin
                        next_state = ID;
                    end else begin
`ifdef SIMPLE_SEQ_TRAP_EN
                        set_trap   = 1'b1;
                        next_state = HALT;
`else
                        skip       = 1'b1;
                        next_state = run ? FETCH : IDLE;
`endif
                    end
                end
            end
            ID: begin
                phase      = 2'd1;
                next_state = EX;
            end
            EX: begin
                phase      = 2'd2;
                next_state = WB;
            end
            WB: begin
                phase         = 2'd3;
                instr_retired = 1'b1;
                next_state    = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         INSTR <= '0;
        else if (fetch_done) INSTR <= imem_rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           pc <= RESET_PC;
        else if (state == WB)  pc <= pc + pc_incr;
`ifndef SIMPLE_SEQ_TRAP_EN
        else if (skip)         pc <= pc + PC_W'(1);
`endif
    end

`ifdef SIMPLE_SEQ_TRAP_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       trap <= 1'b0;
        else if (set_trap) trap <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_simple_seq_ctrl.sv
// Scoreboard bench for simple_seq_ctrl: retirements are matched against queued expectations.
module tb_simple_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [7:0]  pc_incr;
    logic [15:0] INSTR;
    logic [1:0]  phase;
    logic [7:0]  pc;
    logic        instr_retired;
    logic        halted;
`ifdef SIMPLE_SEQ_TRAP_EN
    logic        trap;
`endif

    simple_seq_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_incr       (pc_incr),
        .INSTR         (INSTR),
        .phase         (phase),
        .pc            (pc),
        .instr_retired (instr_retired),
        .halted        (halted)
`ifdef SIMPLE_SEQ_TRAP_EN
        ,
        .trap          (trap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  model_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin : retire_monitor
        exp_t e;
        if (resetn && instr_retired) begin
            if (sb.size() == 0) begin
                check("retire_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("retire_pc", pc, e.pc);
                check("retire_instr", INSTR, e.instr);
            end
        end
    end

    // Waits for a request, holds off ack for 'delay' cycles, then acks with rdata.
    task automatic serve(input logic [15:0] rdata, input int unsigned delay);
        int unsigned n = 0;
        logic [7:0]  a0;
        logic [15:0] i0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", imem_req, 1);
        check("fetch_addr", imem_addr, model_pc);
        a0 = imem_addr;
        i0 = INSTR;
        for (int unsigned i = 0; i < delay; i++) begin
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, a0);
            check("wait_phase", phase, 0);
            check("wait_instr", INSTR, i0);
            tick();
        end
        check("ack_req", imem_req, 1);
        check("ack_addr", imem_addr, a0);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        check("instr_cap", INSTR, rdata);
    endtask

    task automatic run_instr(input logic [15:0] rdata, input int unsigned delay,
                             input logic [7:0] incr, input bit drop_run);
        exp_t e;
        pc_incr  = incr;
        e.pc     = model_pc;
        e.instr  = rdata;
        sb.push_back(e);
        serve(rdata, delay);
        check("req_drop", imem_req, 0);
        check("phase_id", phase, 1);
        tick();
        check("phase_ex", phase, 2);
        if (drop_run) run = 1'b0;
        tick();
        check("phase_wb", phase, 3);
        check("retired_wb", instr_retired, 1);
        check("instr_wb", INSTR, rdata);
        model_pc = model_pc + incr;
        tick();
        check("pc_after_wb", pc, model_pc);
        check("retired_low", instr_retired, 0);
    endtask

    initial begin
        resetn     = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pc_incr    = 8'd1;
        model_pc   = 8'h00;
        tick();
        tick();
        check("rst_phase", phase, 0);
        check("rst_pc", pc, 0);
        check("rst_req", imem_req, 0);
        check("rst_instr", INSTR, 0);
        check("rst_halted", halted, 0);
        check("rst_retired", instr_retired, 0);

        // ack asserted while no request is outstanding must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        resetn     = 1'b1;
        tick();
        check("idle_ack_ignored", INSTR, 0);
        check("idle_req", imem_req, 0);
        imem_ack   = 1'b0;
        run        = 1'b1;

        run_instr(16'h3A55, 0, 8'h01, 1'b0);        // basic, pc 0 -> 1
        run_instr(16'h1234, 3, 8'h01, 1'b0);        // 3 wait states, pc 1 -> 2
        run_instr(16'h5000, 1, 8'hFC, 1'b0);        // pc 2 -> 0xFE
        run_instr(16'h8001, 0, 8'h05, 1'b1);        // wrap 0xFE -> 0x03, run dropped in EX
        for (int i = 0; i < 4; i++) begin
            check("idle_req_low", imem_req, 0);
            check("idle_phase", phase, 0);
            check("idle_pc", pc, 8'h03);
            tick();
        end
        run = 1'b1;
        run_instr(16'h9002, 2, 8'h01, 1'b0);        // pc 3 -> 4

        // illegal opcode at pc=4
        serve(16'h7123, 0);
`ifdef SIMPLE_SEQ_TRAP_EN
        check("trap_set", trap, 1);
        check("trap_halted", halted, 1);
        check("trap_pc", pc, 8'h04);
        check("trap_phase", phase, 0);
        check("trap_req", imem_req, 0);
        tick();
        check("trap_sticky", trap, 1);
        check("trap_pc_hold", pc, 8'h04);
`else
        model_pc = model_pc + 8'd1;
        check("skip_phase", phase, 0);
        check("skip_retired", instr_retired, 0);
        check("skip_req", imem_req, 1);
        check("skip_addr", imem_addr, 8'h05);
        check("skip_halted", halted, 0);
        run_instr(16'h0042, 0, 8'h02, 1'b0);        // pc 5 -> 7
`endif

        // reset asserted in the middle of EX
        resetn = 1'b0;
        tick();
        resetn   = 1'b1;
        model_pc = 8'h00;
        pc_incr  = 8'h01;
        begin
            exp_t e;
            e.pc    = 8'h00;
            e.instr = 16'h4000;
            sb.push_back(e);
        end
        serve(16'h4000, 0);
        check("mid_phase_id", phase, 1);
        tick();
        check("mid_phase_ex", phase, 2);
        #2 resetn = 1'b0;
        #1;
        check("midrst_phase", phase, 0);
        check("midrst_pc", pc, 0);
        check("midrst_req", imem_req, 0);
        check("midrst_instr", INSTR, 0);
        check("midrst_halted", halted, 0);
        sb.delete();
        tick();
        resetn = 1'b1;

        // HALT: frozen, requests stay low, stray acks ignored
        serve(16'hF000, 1);
        check("halt_set", halted, 1);
        check("halt_req", imem_req, 0);
        for (int i = 0; i < 20; i++) begin
            imem_ack   = (i % 3 == 0);
            imem_rdata = 16'h1111;
            tick();
            check("halt_req_low", imem_req, 0);
            check("halt_phase", phase, 0);
            check("halt_pc", pc, 8'h00);
            check("halt_instr", INSTR, 16'hF000);
            check("halt_sticky", halted, 1);
            check("halt_retired", instr_retired, 0);
        end
        imem_ack = 1'b0;
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
